// File: rtl/bram_stream_reader_pkg.sv
// Shared types for the BRAM-to-stream reader.
// FSM encoding and FIFO sizing live here.
package bram_stream_reader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int FIFO_DEPTH = 2;

endpackage

// File: rtl/bram_stream_reader_if.sv
// AXI-Stream bundle with master/slave views.
// Carries data, valid, ready and last.
interface bram_stream_reader_if #(
    parameter int DWIDTH = 32
);
    logic [DWIDTH-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/bram_stream_reader_stream_fifo2.sv
// Two-entry register FIFO holding {last, data}.
// Head is always visible on dout; caller never pushes when full.
module stream_fifo2 #(
    parameter int W = 33
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    output logic [W-1:0] dout,
    output logic [1:0]   occ
);
    logic [W-1:0] e0;
    logic [W-1:0] e1;
    logic         wr_ptr;
    logic         rd_ptr;

    assign dout = rd_ptr ? e1 : e0;

    // Storage, pointers and occupancy update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e0     <= '0;
            e1     <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ    <= 2'd0;
        end else begin
            if (push) begin
                if (wr_ptr) e1 <= din;
                else        e0 <= din;
                wr_ptr <= ~wr_ptr;
            end
            if (pop) rd_ptr <= ~rd_ptr;
            unique case ({push, pop})
                2'b10:   occ <= occ + 2'd1;
                2'b01:   occ <= occ - 2'd1;
                default: occ <= occ;
            endcase
        end
    end
endmodule

// File: rtl/bram_stream_reader.sv
// Reads a block of consecutive BRAM words and streams them out.
// Credit-limited issue keeps FIFO plus in-flight word within two.
module bram_stream_reader
    import bram_stream_reader_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int ADDR_BIT = 32,
    parameter int LEN_BIT  = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_BIT-1:0] base_addr,
    input  logic [LEN_BIT-1:0]  length,
    output logic                busy,
    output logic                done,
    output logic                bram_en,
    output logic                bram_we,
    output logic [ADDR_BIT-1:0] bram_addr,
    input  logic [DWIDTH-1:0]   bram_d_in,
    bram_stream_reader_if.master m_axis
);
    localparam logic [LEN_BIT-1:0] ONE = LEN_BIT'(1);

    state_t              state;
    state_t              state_n;
    logic [ADDR_BIT-1:0] base_q;
    logic [LEN_BIT-1:0]  len_q;
    logic [LEN_BIT-1:0]  issue_cnt;
    logic [LEN_BIT-1:0]  rd_cnt;
    logic                inflight;
    logic                pop;
    logic                push_last;
    logic [1:0]          occ;
    logic [2:0]          credit;
    logic [DWIDTH:0]     head;

    assign bram_we   = 1'b0;
    assign pop       = m_axis.tvalid & m_axis.tready;
    assign push_last = (rd_cnt == len_q - ONE);
    assign credit    = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};

    assign m_axis.tvalid = (occ != 2'd0);
    assign m_axis.tdata  = head[DWIDTH-1:0];
    assign m_axis.tlast  = head[DWIDTH];

    stream_fifo2 #(.W(DWIDTH + 1)) u_fifo (
        .clk  (clk),
        .rst  (rst),
        .push (inflight),
        .din  ({push_last, bram_d_in}),
        .pop  (pop),
        .dout (head),
        .occ  (occ)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    // Next state, status flags and read issue.
    always_comb begin
        state_n   = state;
        busy      = 1'b0;
        done      = 1'b0;
        bram_en   = 1'b0;
        bram_addr = '0;
        unique case (state)
            IDLE: begin
                if (start)
                    state_n = (length == '0) ? DONE : RUN;
            end
            RUN: begin
                busy      = 1'b1;
                bram_addr = base_q + ADDR_BIT'(issue_cnt);
                bram_en   = (issue_cnt < len_q) && (credit < 3'd2);
                if (pop && m_axis.tlast)
                    state_n = DONE;
            end
            DONE: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Transfer setup, issue/read counters and in-flight tracking.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            base_q    <= '0;
            len_q     <= '0;
            issue_cnt <= '0;
            rd_cnt    <= '0;
            inflight  <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                base_q    <= base_addr;
                len_q     <= length;
                issue_cnt <= '0;
                rd_cnt    <= '0;
            end else begin
                if (bram_en)  issue_cnt <= issue_cnt + ONE;
                if (inflight) rd_cnt    <= rd_cnt + ONE;
            end
            inflight <= bram_en;
        end
    end
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader.
// BRAM model returns addr*3 one cycle after enable.
module tb_bram_stream_reader;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [31:0] base_addr = '0;
    logic [15:0] length = '0;
    logic        busy, done, bram_en, bram_we;
    logic [31:0] bram_addr;
    logic [31:0] bram_d_in = '0;

    bram_stream_reader_if #(.DWIDTH(32)) axis ();

    bram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .length    (length),
        .busy      (busy),
        .done      (done),
        .bram_en   (bram_en),
        .bram_we   (bram_we),
        .bram_addr (bram_addr),
        .bram_d_in (bram_d_in),
        .m_axis    (axis)
    );

    always #5 clk = ~clk;

    // BRAM model: 1-cycle read latency, content = addr*3.
    always @(posedge clk) begin
        if (bram_en) bram_d_in <= bram_addr * 32'd3;
    end

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] got_data[$];
    logic        got_last[$];
    int          got_cyc[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          busy_seen = 0;
    int          en_cnt = 0;
    int          issued = 0;
    int          accepted = 0;
    int          max_out = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;
    logic        prev_last = 1'b0;

    // Monitor on the falling edge: beats, stalls, outstanding words.
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
            issued = 0;
            accepted = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(axis.tvalid), 64'd1);
                check("stall_data", 64'(axis.tdata), 64'(prev_data));
                check("stall_last", 64'(axis.tlast), 64'(prev_last));
            end
            if (issued - accepted > max_out) max_out = issued - accepted;
            if (axis.tvalid && axis.tready) begin
                got_data.push_back(axis.tdata);
                got_last.push_back(axis.tlast);
                got_cyc.push_back(cyc);
                accepted++;
            end
            if (bram_en) begin
                issued++;
                en_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen++;
            prev_stall = axis.tvalid && !axis.tready;
            prev_data  = axis.tdata;
            prev_last  = axis.tlast;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        got_data.delete();
        got_last.delete();
        got_cyc.delete();
        busy_seen = 0;
        max_out = 0;
    endtask

    task automatic kick(input logic [31:0] b, input logic [15:0] n,
                        output int t);
        base_addr = b;
        length = n;
        start = 1'b1;
        t = cyc;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int lim,
                             input bit toggle);
        int d0;
        d0 = done_cnt;
        for (int i = 0; i < lim; i++) begin
            if (done_cnt != d0) break;
            tick();
            if (toggle) axis.tready = ~axis.tready;
        end
        if (done_cnt == d0) check({tag, "_timeout"}, 64'd0, 64'd1);
    endtask

    task automatic check_beats(input string tag, input logic [31:0] b,
                               input int n);
        check({tag, "_count"}, 64'(got_data.size()), 64'(n));
        if (got_data.size() == n) begin
            for (int k = 0; k < n; k++) begin
                check({tag, "_data"}, 64'(got_data[k]),
                      64'((b + 32'(k)) * 32'd3));
                check({tag, "_last"}, 64'(got_last[k]),
                      64'(k == n - 1));
            end
        end
    endtask

    initial begin
        int t;
        int en0;
        int d0;
        axis.tready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_en", 64'(bram_en), 64'd0);
        check("rst_we", 64'(bram_we), 64'd0);
        check("rst_addr", 64'(bram_addr), 64'd0);
        check("rst_tvalid", 64'(axis.tvalid), 64'd0);
        check("rst_tlast", 64'(axis.tlast), 64'd0);
        check("rst_tdata", 64'(axis.tdata), 64'd0);
        rst = 1'b0;
        tick();

        // len=4, tready high: beats on T+3..T+6, done at T+7.
        clear_log();
        kick(32'h10, 16'd4, t);
        check("t1_busy", 64'(busy), 64'd1);
        check("t1_en", 64'(bram_en), 64'd1);
        check("t1_addr", 64'(bram_addr), 64'h10);
        wait_done("t1", 40, 1'b0);
        check_beats("t1", 32'h10, 4);
        if (got_cyc.size() == 4) begin
            for (int k = 0; k < 4; k++)
                check("t1_beat_cyc", 64'(got_cyc[k]), 64'(t + 3 + k));
        end
        check("t1_done_cyc", 64'(done_cyc), 64'(t + 7));
        tick();
        check("t1_idle_busy", 64'(busy), 64'd0);

        // len=8 with tready toggling each cycle.
        clear_log();
        kick(32'h40, 16'd8, t);
        wait_done("t2", 100, 1'b1);
        axis.tready = 1'b1;
        check_beats("t2", 32'h40, 8);
        check("t2_max_out", 64'(max_out <= 2), 64'd1);
        tick();

        // len=0: no access, no beats, done at T+1.
        clear_log();
        en0 = en_cnt;
        kick(32'h70, 16'd0, t);
        wait_done("t3", 10, 1'b0);
        repeat (3) tick();
        check("t3_en", 64'(en_cnt - en0), 64'd0);
        check("t3_beats", 64'(got_data.size()), 64'd0);
        check("t3_done_cyc", 64'(done_cyc), 64'(t + 1));
        check("t3_busy", 64'(busy_seen), 64'd0);

        // len=1 held off by tready low for 10 cycles.
        clear_log();
        axis.tready = 1'b0;
        kick(32'h5, 16'd1, t);
        repeat (10) tick();
        check("t4_hold_valid", 64'(axis.tvalid), 64'd1);
        axis.tready = 1'b1;
        wait_done("t4", 20, 1'b0);
        check_beats("t4", 32'h5, 1);
        if (got_cyc.size() == 1)
            check("t4_done_cyc", 64'(done_cyc), 64'(got_cyc[0] + 1));
        tick();

        // Reset after 2 of 6 beats, then a fresh len=3 transfer.
        clear_log();
        kick(32'h20, 16'd6, t);
        for (int i = 0; i < 20; i++) begin
            if (got_data.size() >= 2) break;
            tick();
        end
        check("t5_pre_beats", 64'(got_data.size()), 64'd2);
        rst = 1'b1;
        #1;
        check("t5_busy", 64'(busy), 64'd0);
        check("t5_done", 64'(done), 64'd0);
        check("t5_en", 64'(bram_en), 64'd0);
        check("t5_addr", 64'(bram_addr), 64'd0);
        check("t5_tvalid", 64'(axis.tvalid), 64'd0);
        check("t5_tlast", 64'(axis.tlast), 64'd0);
        check("t5_tdata", 64'(axis.tdata), 64'd0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        clear_log();
        kick(32'h50, 16'd3, t);
        wait_done("t5", 40, 1'b0);
        repeat (4) tick();
        check_beats("t5", 32'h50, 3);

        // Second start during RUN is ignored.
        clear_log();
        d0 = done_cnt;
        kick(32'h60, 16'd5, t);
        tick();
        base_addr = 32'h90;
        length = 16'd2;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_done("t6", 40, 1'b0);
        repeat (5) tick();
        check_beats("t6", 32'h60, 5);
        check("t6_done_cnt", 64'(done_cnt - d0), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule
